// File: rtl/pot_scan.sv
// Round-robin SPI scanner for a multi-channel pot ADC; two 16-bit frames per channel.
// Optional feature: define POT_SCAN_SMOOTH_EN for a 1/4-weight IIR on stored results.
module pot_scan #(
  parameter int NUM_CH    = 5,
  parameter int DATA_W    = 12,
  parameter int SCLK_HALF = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       start,
  output logic                       SS_n,
  output logic                       SCLK,
  output logic                       MOSI,
  input  logic                       MISO,
  output logic [NUM_CH*DATA_W-1:0]   result,
  output logic [NUM_CH-1:0]          res_vld,
  output logic                       scan_done,
  output logic                       busy
);

  // state | meaning
  // IDLE  | SS_n high, waiting for en or start
  // XFER1 | channel-select frame, MISO ignored
  // GAP   | SS_n high between the two frames
  // XFER2 | second frame, conversion shifted in
  // STORE | write result, pulse res_vld / scan_done
  typedef enum logic [2:0] {IDLE, XFER1, GAP, XFER2, STORE} state_t;

  localparam int TMR_W = $clog2(2*SCLK_HALF) + 1;
  localparam logic [TMR_W-1:0] HALF_M1 = TMR_W'(SCLK_HALF - 1);
  localparam logic [TMR_W-1:0] GAP_M1  = TMR_W'(2*SCLK_HALF - 1);
  localparam logic [2:0]       LAST_CH = 3'(NUM_CH - 1);

  state_t            state;
  logic [2:0]        ch;
  logic [TMR_W-1:0]  tmr;
  logic [5:0]        hp;
  logic [15:0]       tx;
  logic [11:0]       rx;
  logic [DATA_W-1:0] sample;
  logic [DATA_W-1:0] store_val;
  logic              last_ch;
  logic [2:0]        nxt_ch;

  function automatic logic [15:0] frame_word(input logic [2:0] c);
    return {2'b00, c, 11'b0};
  endfunction

  assign sample  = rx[11 -: DATA_W];
  assign last_ch = (ch == LAST_CH);
  assign nxt_ch  = last_ch ? 3'd0 : ch + 3'd1;

`ifdef POT_SCAN_SMOOTH_EN
  logic [NUM_CH-1:0]      primed;
  logic [DATA_W-1:0]      old_val;
  logic signed [DATA_W:0] diff;
  logic signed [DATA_W:0] acc;

  always_comb begin
    old_val = '0;
    for (int k = 0; k < NUM_CH; k++)
      if (ch == 3'(k)) old_val = result[k*DATA_W +: DATA_W];
  end

  assign diff      = $signed({1'b0, sample}) - $signed({1'b0, old_val});
  assign acc       = $signed({1'b0, old_val}) + (diff >>> 2);
  assign store_val = acc[DATA_W-1:0];
`else
  assign store_val = sample;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ch        <= '0;
      tmr       <= '0;
      hp        <= '0;
      tx        <= '0;
      rx        <= '0;
      SS_n      <= 1'b1;
      SCLK      <= 1'b1;
      MOSI      <= 1'b0;
      result    <= '0;
      res_vld   <= '0;
      scan_done <= 1'b0;
      busy      <= 1'b0;
`ifdef POT_SCAN_SMOOTH_EN
      primed    <= '0;
`endif
    end else begin
      res_vld   <= '0;
      scan_done <= 1'b0;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (en || (start && !busy)) begin
            state <= XFER1;
            busy  <= 1'b1;
            SS_n  <= 1'b0;
            SCLK  <= 1'b1;
            tmr   <= HALF_M1;
            hp    <= '0;
            tx    <= frame_word(ch);
          end
        end

        // hp walks the half-periods: 0 lead-in, odd = SCLK low, even = SCLK high, 32 trail
        XFER1, XFER2: begin
          if (tmr != '0) begin
            tmr <= tmr - 1'b1;
          end else begin
            tmr <= HALF_M1;
            hp  <= hp + 6'd1;
            if (hp == 6'd32) begin
              SS_n <= 1'b1;
              MOSI <= 1'b0;
              if (state == XFER1) begin
                state <= GAP;
                tmr   <= GAP_M1;
              end else begin
                state <= STORE;
              end
            end else if (!hp[0]) begin
              SCLK <= 1'b0;
              MOSI <= tx[15];
              tx   <= {tx[14:0], 1'b0};
            end else begin
              SCLK <= 1'b1;
              rx   <= {rx[10:0], MISO};
            end
          end
        end

        GAP: begin
          if (tmr != '0) begin
            tmr <= tmr - 1'b1;
          end else begin
            state <= XFER2;
            SS_n  <= 1'b0;
            tmr   <= HALF_M1;
            hp    <= '0;
            tx    <= frame_word(ch);
          end
        end

        STORE: begin
          for (int k = 0; k < NUM_CH; k++) begin
            if (ch == 3'(k)) begin
`ifdef POT_SCAN_SMOOTH_EN
              result[k*DATA_W +: DATA_W] <= primed[k] ? store_val : sample;
              primed[k]                  <= 1'b1;
`else
              result[k*DATA_W +: DATA_W] <= store_val;
`endif
              res_vld[k] <= 1'b1;
            end
          end
          ch <= nxt_ch;
          if (last_ch) scan_done <= 1'b1;
          // en is only consulted at the scan boundary so a scan always completes
          if (!last_ch || en) begin
            state <= XFER1;
            SS_n  <= 1'b0;
            SCLK  <= 1'b1;
            tmr   <= HALF_M1;
            hp    <= '0;
            tx    <= frame_word(nxt_ch);
          end else begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
